// File: rtl/mux_scan_serializer_pkg.sv
// Shared types and constants for the mux scan serializer.
// State encoding and select start/end helpers.
package mux_scan_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEL_W = 4;

  // First select position of a frame.
  function automatic int sel_start(input int sel_w, input int msb_first);
    return (msb_first != 0) ? (2 ** sel_w) - 1 : 0;
  endfunction

  // Select position of the final bit of a frame.
  function automatic int sel_last(input int sel_w, input int msb_first);
    return (msb_first != 0) ? 0 : (2 ** sel_w) - 1;
  endfunction

endpackage

// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial front end for a 16:1 select mux.
// Holds a word, steps the select, registers the mux bit.
module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             hold,
  output logic [WIDTH-1:0] word_out,
  output logic [SEL_W-1:0] sel_out,
  input  logic             mux_bit,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [SEL_W-1:0] START =
    SEL_W'(sel_start(SEL_W, MSB_FIRST));

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] word_d;
  logic [SEL_W-1:0] sel_d, sel_step;
  logic             ser_d, sv_d, fd_d;

  assign load_ready = (state == ST_IDLE);

  assign sel_step = (MSB_FIRST != 0) ? sel_out - 1'b1
                                     : sel_out + 1'b1;

  // Next-state and datapath decode for load and shift.
  always_comb begin
    state_d = state;
    word_d  = word_out;
    sel_d   = sel_out;
    cnt_d   = cnt;
    ser_d   = ser_out;
    sv_d    = 1'b0;
    fd_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_valid) begin
          word_d  = load_data;
          sel_d   = START;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!hold) begin
          ser_d = mux_bit;
          sv_d  = 1'b1;
          sel_d = sel_step;
          cnt_d = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            fd_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      word_out   <= '0;
      sel_out    <= '0;
      cnt        <= '0;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      word_out   <= word_d;
      sel_out    <= sel_d;
      cnt        <= cnt_d;
      ser_out    <= ser_d;
      ser_valid  <= sv_d;
      frame_done <= fd_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer, LSB- and MSB-first builds.
// Reference model works on word index and bit order.
module tb_mux_scan_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_data;
  logic        hold;

  logic        rdy_l, rdy_m;
  logic [15:0] word_l, word_m;
  logic [3:0]  sel_l, sel_m;
  logic        mbit_l, mbit_m;
  logic        ser_l, ser_m;
  logic        sv_l, sv_m;
  logic        fd_l, fd_m;

  int n_vec = 0;
  int n_err = 0;

  // model state
  bit          e_busy;
  logic [15:0] e_word;
  int          e_idx;
  logic        e_ser_l, e_ser_m, e_sv, e_fd;
  logic [15:0] cap;

  always #5 clk = ~clk;

  // stand-ins for the external 16:1 mux
  assign mbit_l = word_l[sel_l];
  assign mbit_m = word_m[sel_m];

  mux_scan_serializer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(rdy_l),
    .load_data(load_data), .hold(hold),
    .word_out(word_l), .sel_out(sel_l), .mux_bit(mbit_l),
    .ser_out(ser_l), .ser_valid(sv_l), .frame_done(fd_l)
  );

  mux_scan_serializer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(rdy_m),
    .load_data(load_data), .hold(hold),
    .word_out(word_m), .sel_out(sel_m), .mux_bit(mbit_m),
    .ser_out(ser_m), .ser_valid(sv_m), .frame_done(fd_m)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_busy  = 1'b0;
    e_word  = '0;
    e_idx   = 0;
    e_ser_l = 1'b0;
    e_ser_m = 1'b0;
    e_sv    = 1'b0;
    e_fd    = 1'b0;
  endtask

  task automatic check_all();
    chk("rdy_l", rdy_l, !e_busy);
    chk("rdy_m", rdy_m, !e_busy);
    chk("sv_l", sv_l, e_sv);
    chk("sv_m", sv_m, e_sv);
    chk("fd_l", fd_l, e_fd);
    chk("fd_m", fd_m, e_fd);
    chk("ser_l", ser_l, e_ser_l);
    chk("ser_m", ser_m, e_ser_m);
    chk("word_l", word_l, e_word);
    chk("word_m", word_m, e_word);
    if (e_busy) begin
      chk("sel_l", sel_l, 16'(e_idx));
      chk("sel_m", sel_m, 16'(15 - e_idx));
    end
  endtask

  // One clock: predict from the inputs present at the edge.
  task automatic tick();
    e_sv = 1'b0;
    e_fd = 1'b0;
    if (!e_busy) begin
      if (load_valid) begin
        e_busy = 1'b1;
        e_word = load_data;
        e_idx  = 0;
      end
    end else if (!hold) begin
      e_ser_l = e_word[e_idx];
      e_ser_m = e_word[15 - e_idx];
      e_sv    = 1'b1;
      e_fd    = (e_idx == 15);
      e_idx++;
      if (e_idx == 16) e_busy = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Load one word and run until frame_done, capturing LSB stream.
  task automatic run_frame(input logic [15:0] w);
    int guard;
    load_data  = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    cap   = '0;
    guard = 0;
    do begin
      tick();
      if (sv_l) cap = {ser_l, cap[15:1]};
      guard++;
    end while (!fd_l && guard < 40);
    chk("frame_timeout", 16'(guard >= 40), 16'd0);
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    hold       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2 reset = 1'b0;

    // plain frame, captured stream must rebuild the word
    run_frame(16'hA5C3);
    chk("a5c3_stream", cap, 16'hA5C3);
    tick();

    // stall for 3 cycles after the 5th bit
    load_data  = 16'h3C96;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (5) tick();
    hold = 1'b1;
    repeat (3) begin
      tick();
      chk("hold_sel", sel_l, 16'd5);
    end
    hold = 1'b0;
    repeat (11) tick();
    chk("hold_end_fd", fd_l, 1'b1);
    tick();

    // back-to-back words with valid held high
    load_valid = 1'b1;
    load_data  = 16'hFFFF;
    tick();
    load_data  = 16'h0000;
    repeat (16) tick();
    chk("b2b_fd", fd_l, 1'b1);
    tick();
    chk("b2b_gap", sv_l, 1'b0);
    tick();
    chk("b2b_resume", sv_l, 1'b1);
    load_valid = 1'b0;
    repeat (15) tick();
    tick();

    // reset after the 7th bit
    load_data  = 16'hBEEF;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (7) tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #2 reset = 1'b0;
    run_frame(16'h5A0F);
    chk("post_reset_stream", cap, 16'h5A0F);
    tick();

    // load_valid pulsed mid-frame is ignored
    load_data  = 16'h8001;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (4) tick();
    load_data  = 16'h1234;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("ignore_word", word_l, 16'h8001);
    repeat (11) tick();
    chk("ignore_fd", fd_l, 1'b1);
    tick();

    // randomized valid/hold/data traffic
    for (int i = 0; i < 400; i++) begin
      load_valid = 1'($urandom_range(0, 1));
      load_data  = 16'($urandom);
      hold       = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
